// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with a run/pause/clear control FSM, a one-second prescaler
// and a BCD digit cascade that wraps 59:59 -> 00:00 with a rollover pulse.
module stopwatch_counter #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescale;

    // Control, prescaler and time all live in one register block so that a
    // terminal-count edge can both advance time and honour start_stop/clear.
    always_ff @(posedge clk) begin
        rollover <= 1'b0;
        if (rst || clear) begin
            state    <= IDLE;
            running  <= 1'b0;
            prescale <= '0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (start_stop) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (start_stop) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase

            if (state == RUNNING) begin
                if (prescale == LAST) begin
                    prescale <= '0;
                    // Each digit carries into the next only when it wraps.
                    if (sec_ones != 4'd9) begin
                        sec_ones <= sec_ones + 4'd1;
                    end else begin
                        sec_ones <= 4'd0;
                        if (sec_tens != 4'd5) begin
                            sec_tens <= sec_tens + 4'd1;
                        end else begin
                            sec_tens <= 4'd0;
                            if (min_ones != 4'd9) begin
                                min_ones <= min_ones + 4'd1;
                            end else begin
                                min_ones <= 4'd0;
                                if (min_tens != 4'd5) begin
                                    min_tens <= min_tens + 4'd1;
                                end else begin
                                    min_tens <= 4'd0;
                                    rollover <= 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    prescale <= prescale + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus random
// control pulses, all compared against a seconds-based reference model.
module tb_stopwatch_counter;

    localparam int T = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;

    int vectors = 0;
    int miscompares = 0;

    int mState = M_IDLE;
    int mPre = 0;
    int mSecs = 0;
    bit mRoll = 1'b0;

    stopwatch_counter #(.TICKS_PER_SEC(T)) dut (
        .clk(clk),
        .rst(rst),
        .start_stop(start_stop),
        .clear(clear),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .running(running),
        .rollover(rollover)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    function automatic logic [15:0] toDigits(input int s);
        int m;
        int sec;
        m = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Reference model: elapsed time as a plain seconds count modulo one hour.
    task automatic modelStep(input bit ss, input bit cl, input bit rs);
        mRoll = 1'b0;
        if (rs || cl) begin
            mState = M_IDLE;
            mPre = 0;
            mSecs = 0;
        end else begin
            if (mState == M_RUN) begin
                mPre++;
                if (mPre == T) begin
                    mPre = 0;
                    mSecs = (mSecs + 1) % 3600;
                    mRoll = (mSecs == 0);
                end
            end
            if (ss) mState = (mState == M_RUN) ? M_PAUSE : M_RUN;
        end
    endtask

    task automatic applyStimulus(input bit ss, input bit cl, input bit rs);
        start_stop = ss;
        clear = cl;
        rst = rs;
        @(posedge clk);
        modelStep(ss, cl, rs);
        #1;
        start_stop = 1'b0;
        clear = 1'b0;
        rst = 1'b0;
        checkOutput("model_digits", digits(), toDigits(mSecs));
        checkOutput("model_running", 16'(running), 16'(mState == M_RUN));
        checkOutput("model_rollover", 16'(rollover), 16'(mRoll));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_digits", digits(), 16'h0000);
        checkOutput("reset_running", 16'(running), 16'h0);
        checkOutput("reset_rollover", 16'(rollover), 16'h0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(40);
        checkOutput("run40_digits", digits(), 16'h0010);
        checkOutput("run40_running", 16'(running), 16'h1);
        checkOutput("run40_rollover", 16'(rollover), 16'h0);

        // Pause at 00:07 with the pause edge consuming one tick of the second.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(28);
        checkOutput("at7_digits", digits(), 16'h0007);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(20);
        checkOutput("paused_digits", digits(), 16'h0007);
        checkOutput("paused_running", 16'(running), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("resume_hold", digits(), 16'h0007);
        idleCycles(1);
        checkOutput("resume_8", digits(), 16'h0008);

        // Full hour wrap.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(3599 * T);
        checkOutput("preload_5959", digits(), 16'h5959);
        idleCycles(T - 1);
        checkOutput("prewrap_roll", 16'(rollover), 16'h0);
        idleCycles(1);
        checkOutput("wrap_digits", digits(), 16'h0000);
        checkOutput("wrap_roll", 16'(rollover), 16'h1);
        checkOutput("wrap_running", 16'(running), 16'h1);
        idleCycles(1);
        checkOutput("postwrap_roll", 16'(rollover), 16'h0);

        // Clear and start_stop together at 01:23.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(83 * T + 2);
        checkOutput("at0123", digits(), 16'h0123);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clrss_digits", digits(), 16'h0000);
        checkOutput("clrss_running", 16'(running), 16'h0);
        idleCycles(2 * T);
        checkOutput("clrss_idle", digits(), 16'h0000);

        // Clear on the terminal-count edge at 00:09.
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(9 * T + T - 1);
        checkOutput("at9", digits(), 16'h0009);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clrtc_digits", digits(), 16'h0000);
        checkOutput("clrtc_roll", 16'(rollover), 16'h0);

        // start_stop on the terminal-count edge still advances time.
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2 * T + T - 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sstc_digits", digits(), 16'h0003);
        checkOutput("sstc_running", 16'(running), 16'h0);

        // Reset mid-second at 12:34 overrides clear and start_stop.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(754 * T + 2);
        checkOutput("at1234", digits(), 16'h1234);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rst_digits", digits(), 16'h0000);
        checkOutput("rst_running", 16'(running), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(T - 1);
        checkOutput("rst_partial", digits(), 16'h0000);
        idleCycles(1);
        checkOutput("rst_full", digits(), 16'h0001);

        // Random control pulses.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(7) == 0), ($urandom_range(63) == 0),
                          ($urandom_range(255) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000: clk cycles per counted second, legal range >= 2.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_stop  input  1  single-cycle, already-synchronized pulse that toggles run/pause.
REQ-005 SHALL have port clear  input  1  single-cycle, already-synchronized pulse that zeroes time and stops counting.
REQ-006 SHALL have port sec_ones  output  4  BCD seconds units, 0-9, registered.
REQ-007 SHALL have port sec_tens  output  4  BCD seconds tens, 0-5, registered.
REQ-008 SHALL have port min_ones  output  4  BCD minutes units, 0-9, registered.
REQ-009 SHALL have port min_tens  output  4  BCD minutes tens, 0-5, registered.
REQ-010 SHALL have port running  output  1  high while the state is RUNNING, registered.
REQ-011 SHALL have port rollover  output  1  one-cycle pulse when time wraps 59:59 -> 00:00, registered.

Function
REQ-012 SHALL implement states IDLE, RUNNING, PAUSED; running = (state == RUNNING).
REQ-013 SHALL transition on start_stop: IDLE -> RUNNING, RUNNING -> PAUSED, PAUSED -> RUNNING.
REQ-014 SHALL, on clear in any state, go to IDLE, set all four digits to 0 and the prescaler to 0 at that edge.
REQ-015 SHALL give clear priority over start_stop when both are high in the same cycle; start_stop is ignored.
REQ-016 SHALL keep a prescaler of width clog2(TICKS_PER_SEC) counting 0..TICKS_PER_SEC-1, advancing only on edges where state is RUNNING.
REQ-017 SHALL, on an edge where state is RUNNING and prescaler == TICKS_PER_SEC-1, load the prescaler with 0 and advance time by one second at that same edge.
REQ-018 SHALL advance time as a BCD cascade: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 completes the wrap.
REQ-019 SHALL, on the 59:59 -> 00:00 advance, keep counting (state stays RUNNING) and assert rollover for exactly the following cycle.
REQ-020 SHALL hold digits and prescaler unchanged in IDLE and PAUSED, so resume continues the partial second.
REQ-021 SHALL still apply the time advance when start_stop arrives on the terminal-count edge in RUNNING; the state then becomes PAUSED.
REQ-022 SHALL suppress the advance and rollover when clear coincides with the terminal count; digits become 00:00.
REQ-023 SHALL change digits exactly TICKS_PER_SEC edges after the edge that samples start_stop in IDLE.
REQ-024 SHALL never output a non-BCD digit value (sec_tens/min_tens > 5, or ones > 9).

Reset
REQ-025 SHALL, with rst high at an edge, set state IDLE, prescaler 0, all digits 0, running 0, rollover 0.
REQ-026 SHALL give rst priority over clear and start_stop, including during RUNNING mid-second.

Verification (TICKS_PER_SEC = 4)
REQ-027 SHALL check: reset, then start_stop pulse, then 40 cycles -> digits 00:10, running = 1, no rollover.
REQ-028 SHALL check: run to 00:07, start_stop (pause), idle 20 cycles, start_stop again -> still 00:07 during the pause; the partial second resumes and 00:08 is reached 4 edges after the pause edge, counting running edges only.
REQ-029 SHALL check: preload by running 3599 s, then one more second -> 59:59 -> 00:00, rollover high exactly one cycle, running stays 1.
REQ-030 SHALL check: clear and start_stop in the same cycle while RUNNING at 01:23 -> 00:00, IDLE, running = 0.
REQ-031 SHALL check: clear on the terminal-count edge at 00:09 -> 00:00, no carry into sec_tens.
REQ-032 SHALL check: rst asserted mid-second in RUNNING at 12:34 -> all outputs 0 at the next edge; a new start_stop takes a full 4 edges to reach 00:01.
